// File: rtl/pipe_hazard_sequencer_pkg.sv
// Shared definitions for the pipeline hazard sequencer: state codes,
// default widths and the bundled control-output struct.
package hazard_pkg;

    localparam int XLEN_DEF = 32;

    // Sequencer states
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_REDIR = 2'd2;

    // Per-cycle control outputs, grouped so the next-state logic can
    // clear them in one go.
    typedef struct packed {
        logic pc_we;
        logic pc_sel;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
    } ctl_t;

    // Set all four pipeline register enables to the same value
    function automatic ctl_t ctl_set_en(input ctl_t c, input logic en);
        ctl_t r;
        r           = c;
        r.if_id_en  = en;
        r.id_ex_en  = en;
        r.ex_mem_en = en;
        r.mem_wb_en = en;
        return r;
    endfunction

endpackage

// File: rtl/pipe_hazard_sequencer_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value
);

    // Count up on inc, stop at the top
    always_ff @(posedge clk) begin
        if (rst)
            value <= '0;
        else if (inc && !(&value))
            value <= value + 1'b1;
    end

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Central stall/flush sequencer for the 5-stage pipeline. Combines load-use,
// EX redirect, fetch latency and data-memory busy into per-stage enables,
// flushes and PC controls. A redirect that arrives while the wrong-path fetch
// is still in flight is parked in redirect_q until that response is consumed.
module pipe_hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_use_hz,
    input  logic             jb_taken,
    input  logic [XLEN-1:0]  jb_target,
    input  logic             if_rsp_valid,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             pc_sel,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    logic [1:0]      state, state_nxt;
    logic [XLEN-1:0] redirect_q, redirect_q_nxt;
    logic            redir_acc;
    ctl_t            ctl;

    // Control outputs and next state; priority rst > mem_busy > jb_taken >
    // ld_use_hz > fetch wait
    always_comb begin
        ctl            = '0;
        state_nxt      = state;
        redirect_q_nxt = redirect_q;
        redir_acc      = 1'b0;
        if (rst) begin
            ctl.if_id_flush = 1'b1;
            ctl.id_ex_flush = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_busy) begin
                        // full freeze; upstream holds jb_taken/ld_use_hz
                    end else if (jb_taken) begin
                        redir_acc       = 1'b1;
                        ctl             = ctl_set_en(ctl, 1'b1);
                        ctl.if_id_flush = 1'b1;
                        ctl.id_ex_flush = 1'b1;
                        if (if_rsp_valid) begin
                            ctl.pc_we  = 1'b1;
                            ctl.pc_sel = 1'b1;
                        end else begin
                            // wrong-path fetch in flight: park the target
                            redirect_q_nxt = jb_target;
                            state_nxt      = ST_DRAIN;
                        end
                    end else if (ld_use_hz) begin
                        ctl             = ctl_set_en(ctl, 1'b1);
                        ctl.if_id_en    = 1'b0;
                        ctl.id_ex_flush = 1'b1;
                    end else if (!if_rsp_valid) begin
                        ctl             = ctl_set_en(ctl, 1'b1);
                        ctl.if_id_flush = 1'b1;
                    end else begin
                        ctl       = ctl_set_en(ctl, 1'b1);
                        ctl.pc_we = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    ctl             = ctl_set_en(ctl, !mem_busy);
                    ctl.if_id_flush = 1'b1;
                    if (jb_taken && !mem_busy) begin
                        redirect_q_nxt = jb_target;
                        redir_acc      = 1'b1;
                    end
                    // the stale response is dropped whatever mem_busy says
                    if (if_rsp_valid) begin
                        if (mem_busy) begin
                            state_nxt = ST_REDIR;
                        end else begin
                            ctl.pc_we  = 1'b1;
                            ctl.pc_sel = 1'b1;
                            state_nxt  = ST_RUN;
                        end
                    end
                end
                ST_REDIR: begin
                    if (!mem_busy) begin
                        ctl             = ctl_set_en(ctl, 1'b1);
                        ctl.pc_we       = 1'b1;
                        ctl.pc_sel      = 1'b1;
                        ctl.if_id_flush = 1'b1;
                        state_nxt       = ST_RUN;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    // State and parked redirect target
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            redirect_q <= '0;
        end else begin
            state      <= state_nxt;
            redirect_q <= redirect_q_nxt;
        end
    end

    assign redirect_pc = (state == ST_RUN) ? jb_target : redirect_q;
    assign pc_we       = ctl.pc_we;
    assign pc_sel      = ctl.pc_sel;
    assign if_id_en    = ctl.if_id_en;
    assign id_ex_en    = ctl.id_ex_en;
    assign ex_mem_en   = ctl.ex_mem_en;
    assign mem_wb_en   = ctl.mem_wb_en;
    assign if_id_flush = ctl.if_id_flush;
    assign id_ex_flush = ctl.id_ex_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!rst && !ctl.pc_we),
        .value (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redir_acc),
        .value (redirect_cnt)
    );

endmodule
